// File: rtl/prt_vtb_ctl_pkg.sv
// Shared definitions for the Video Toolbox control block.
// Holds the local-bus address map, CTL/STATUS bit positions, the VPS commit
// FSM state type, bus/register structs and small index helpers.
package prt_vtb_ctl_pkg;

    localparam logic [7:0] ADR_CTL = 8'd0;
    localparam logic [7:0] ADR_IG  = 8'd1;
    localparam logic [7:0] ADR_OG  = 8'd2;
    localparam logic [7:0] ADR_VPS = 8'd3;
    localparam logic [7:0] ADR_STS = 8'd4;

    localparam int CTL_AINC   = 24;
    localparam int CTL_COMMIT = 25;
    localparam int CTL_IMM    = 26;

    localparam int STS_OVR  = 2;
    localparam int STS_WERR = 3;

    typedef enum logic [1:0] {IDLE, PEND, COPY} vps_state_e;

    typedef struct packed {
        logic [7:0]  adr;
        logic        wr;
        logic        rd;
        logic [31:0] din;
    } lb_t;

    typedef struct packed {
        logic       imm;
        logic       ainc;
        logic [7:0] vps_idx;
        logic [7:0] og_idx;
        logic [7:0] ig_idx;
    } ctl_t;

    typedef struct packed {
        logic acc;  // data access (rd or wr) decoded this cycle
        logic ok;   // current index is within the port range
    } port_acc_t;

    typedef port_acc_t ig_acc_t;
    typedef port_acc_t og_acc_t;

    function automatic logic idx_in_range(input logic [7:0] idx, input int unsigned n);
        return 32'(idx) < n;
    endfunction

    // Any index at or beyond the last slot restarts at 0.
    function automatic logic [7:0] idx_next(input logic [7:0] idx, input int unsigned n);
        return (32'(idx) >= n - 1) ? 8'h00 : idx + 8'd1;
    endfunction

endpackage

// File: rtl/prt_vtb_ctl_mc_if.sv
// Local-bus interface: address, write/read strobes, write data in,
// read data out and read-valid.
// lb_in  : slave side (the control block)
// lb_out : master side (the bus driver)
interface prt_dp_lb_if;
    logic [7:0]  adr;
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [31:0] dout;
    logic        vld;

    modport lb_in  (input adr, wr, rd, din, output dout, vld);
    modport lb_out (output adr, wr, rd, din, input dout, vld);
endinterface

// File: rtl/prt_vtb_vps_seq.sv
// VPS double-buffer sequencer.
// Holds the shadow and active tables, the IDLE/PEND/COPY commit FSM, the
// sticky overrun/write-error flags and the commit counter, and streams the
// table as an indexed burst.
// Ports: clk/rst_n; sof; commit/imm request; shadow write (we/waddr/wdat);
// shadow read (raddr/rdat); flag clears; status (pend/busy/ovr/werr/ccnt);
// stream (idx/dat/vld/done).
module prt_vtb_vps_seq
    import prt_vtb_ctl_pkg::*;
#(
    parameter int P_VPS_DEPTH = 16,
    parameter int P_VPS_WIDTH = 16,
    localparam int AW = $clog2(P_VPS_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sof,
    input  logic                   commit,
    input  logic                   imm,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [P_VPS_WIDTH-1:0] wdat,
    input  logic [AW-1:0]          raddr,
    output logic [P_VPS_WIDTH-1:0] rdat,
    input  logic                   ovr_clr,
    input  logic                   werr_clr,
    output logic                   pend,
    output logic                   busy,
    output logic                   ovr,
    output logic                   werr,
    output logic [7:0]             ccnt,
    output logic [AW-1:0]          idx,
    output logic [P_VPS_WIDTH-1:0] dat,
    output logic                   vld,
    output logic                   done
);

    localparam logic [AW-1:0] LAST = AW'(P_VPS_DEPTH - 1);

    vps_state_e             state;
    logic [AW-1:0]          cnt;
    logic [P_VPS_WIDTH-1:0] shadow [P_VPS_DEPTH];
    logic [P_VPS_WIDTH-1:0] active [P_VPS_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            ovr   <= 1'b0;
            werr  <= 1'b0;
            ccnt  <= '0;
            for (int unsigned i = 0; i < P_VPS_DEPTH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            done <= 1'b0;

            if (we && state != COPY) shadow[waddr] <= wdat;

            // A new event wins over a clear arriving in the same cycle.
            if (commit && state != IDLE) ovr <= 1'b1;
            else if (ovr_clr)            ovr <= 1'b0;
            if (we && state == COPY)     werr <= 1'b1;
            else if (werr_clr)           werr <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (commit) state <= imm ? COPY : PEND;
                end
                PEND: begin
                    if (sof) state <= COPY;
                end
                COPY: begin
                    active[cnt] <= shadow[cnt];
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        done  <= 1'b1;
                        ccnt  <= ccnt + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stream outputs decode straight from state so an async reset zeroes
    // them at once.
    assign busy = (state == COPY);
    assign pend = (state == PEND);
    assign vld  = busy;
    assign idx  = busy ? cnt : '0;
    assign dat  = busy ? shadow[cnt] : '0;
    assign rdat = shadow[raddr];

endmodule

// File: rtl/prt_vtb_ctl.sv
// Video Toolbox control block top.
// Registered local bus (stage 1 decode/update, stage 2 read data), CTL
// index/auto-increment register, ingress readback, outgress drive registers
// and STATUS, wrapped around the VPS double-buffer sequencer.
// Ports: SYS_CLK_IN/SYS_RST_IN (async active-low); LB_IF local bus;
// IG_IN ingress words; OG_OUT outgress words; SOF_IN start-of-frame;
// VPS_IDX_OUT/VPS_DAT_OUT/VPS_VLD_OUT/VPS_DONE_OUT table stream.
module prt_vtb_ctl_mc
    import prt_vtb_ctl_pkg::*;
#(
    parameter     P_VENDOR    = "none",
    parameter int P_IG_PORTS  = 8,
    parameter int P_OG_PORTS  = 8,
    parameter int P_VPS_DEPTH = 16,
    parameter int P_VPS_WIDTH = 16
) (
    input  logic                           SYS_CLK_IN,
    input  logic                           SYS_RST_IN,
    prt_dp_lb_if.lb_in                     LB_IF,
    input  logic [P_IG_PORTS*32-1:0]       IG_IN,
    output logic [P_OG_PORTS*32-1:0]       OG_OUT,
    input  logic                           SOF_IN,
    output logic [$clog2(P_VPS_DEPTH)-1:0] VPS_IDX_OUT,
    output logic [P_VPS_WIDTH-1:0]         VPS_DAT_OUT,
    output logic                           VPS_VLD_OUT,
    output logic                           VPS_DONE_OUT
);

    localparam int VAW = $clog2(P_VPS_DEPTH);
    localparam int IGW = (P_IG_PORTS > 1) ? $clog2(P_IG_PORTS) : 1;
    localparam int OGW = (P_OG_PORTS > 1) ? $clog2(P_OG_PORTS) : 1;

    lb_t                    lb_q;
    ctl_t                   ctl_q;
    logic [31:0]            og_q [P_OG_PORTS];
    logic [31:0]            ig_w [P_IG_PORTS];
    logic [31:0]            rdata;
    ig_acc_t                ig_acc;
    og_acc_t                og_acc;
    logic                   vps_acc, vps_ok, vps_we;
    logic                   wr_ctl, wr_sts, commit, ovr_clr, werr_clr;
    logic [P_VPS_WIDTH-1:0] vps_rdat;
    logic                   pend, busy, ovr, werr;
    logic [7:0]             ccnt;

    for (genvar g = 0; g < P_IG_PORTS; g++) begin : g_ig
        assign ig_w[g] = IG_IN[g*32 +: 32];
    end
    for (genvar g = 0; g < P_OG_PORTS; g++) begin : g_og
        assign OG_OUT[g*32 +: 32] = og_q[g];
    end

    always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
        if (!SYS_RST_IN) begin
            lb_q <= '0;
        end else begin
            lb_q.adr <= LB_IF.adr;
            lb_q.wr  <= LB_IF.wr;
            lb_q.rd  <= LB_IF.rd;
            lb_q.din <= LB_IF.din;
        end
    end

    always_comb begin
        ig_acc.acc = (lb_q.wr || lb_q.rd) && lb_q.adr == ADR_IG;
        ig_acc.ok  = idx_in_range(ctl_q.ig_idx, P_IG_PORTS);
        og_acc.acc = (lb_q.wr || lb_q.rd) && lb_q.adr == ADR_OG;
        og_acc.ok  = idx_in_range(ctl_q.og_idx, P_OG_PORTS);
        vps_acc    = (lb_q.wr || lb_q.rd) && lb_q.adr == ADR_VPS;
        vps_ok     = idx_in_range(ctl_q.vps_idx, P_VPS_DEPTH);
        vps_we     = lb_q.wr && lb_q.adr == ADR_VPS && vps_ok;
        wr_ctl     = lb_q.wr && lb_q.adr == ADR_CTL;
        wr_sts     = lb_q.wr && lb_q.adr == ADR_STS;
        commit     = wr_ctl && lb_q.din[CTL_COMMIT];
        ovr_clr    = wr_sts && lb_q.din[STS_OVR];
        werr_clr   = wr_sts && lb_q.din[STS_WERR];
    end

    always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
        if (!SYS_RST_IN) begin
            ctl_q <= '0;
        end else if (wr_ctl) begin
            ctl_q.ig_idx  <= lb_q.din[7:0];
            ctl_q.og_idx  <= lb_q.din[15:8];
            ctl_q.vps_idx <= lb_q.din[23:16];
            ctl_q.ainc    <= lb_q.din[CTL_AINC];
            ctl_q.imm     <= lb_q.din[CTL_IMM];
        end else if (ctl_q.ainc) begin
            if (ig_acc.acc) ctl_q.ig_idx  <= idx_next(ctl_q.ig_idx, P_IG_PORTS);
            if (og_acc.acc) ctl_q.og_idx  <= idx_next(ctl_q.og_idx, P_OG_PORTS);
            if (vps_acc)    ctl_q.vps_idx <= idx_next(ctl_q.vps_idx, P_VPS_DEPTH);
        end
    end

    always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
        if (!SYS_RST_IN) begin
            for (int unsigned i = 0; i < P_OG_PORTS; i++) og_q[i] <= '0;
        end else if (lb_q.wr && og_acc.acc && og_acc.ok) begin
            og_q[ctl_q.og_idx[OGW-1:0]] <= lb_q.din;
        end
    end

    // Read mux sees pre-update register values, so a same-cycle wr+rd
    // returns the old contents.
    always_comb begin
        rdata = '0;
        case (lb_q.adr)
            ADR_CTL: rdata = {5'b0, ctl_q.imm, 1'b0, ctl_q.ainc,
                              ctl_q.vps_idx, ctl_q.og_idx, ctl_q.ig_idx};
            ADR_IG:  if (ig_acc.ok) rdata = ig_w[ctl_q.ig_idx[IGW-1:0]];
            ADR_OG:  if (og_acc.ok) rdata = og_q[ctl_q.og_idx[OGW-1:0]];
            ADR_VPS: if (vps_ok)    rdata = 32'(vps_rdat);
            ADR_STS: rdata = {16'b0, ccnt, 4'b0, werr, ovr, busy, pend};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
        if (!SYS_RST_IN) begin
            LB_IF.dout <= '0;
            LB_IF.vld  <= 1'b0;
        end else begin
            LB_IF.dout <= lb_q.rd ? rdata : '0;
            LB_IF.vld  <= lb_q.rd;
        end
    end

    prt_vtb_vps_seq #(
        .P_VPS_DEPTH (P_VPS_DEPTH),
        .P_VPS_WIDTH (P_VPS_WIDTH)
    ) u_seq (
        .clk      (SYS_CLK_IN),
        .rst_n    (SYS_RST_IN),
        .sof      (SOF_IN),
        .commit   (commit),
        .imm      (lb_q.din[CTL_IMM]),
        .we       (vps_we),
        .waddr    (ctl_q.vps_idx[VAW-1:0]),
        .wdat     (lb_q.din[P_VPS_WIDTH-1:0]),
        .raddr    (ctl_q.vps_idx[VAW-1:0]),
        .rdat     (vps_rdat),
        .ovr_clr  (ovr_clr),
        .werr_clr (werr_clr),
        .pend     (pend),
        .busy     (busy),
        .ovr      (ovr),
        .werr     (werr),
        .ccnt     (ccnt),
        .idx      (VPS_IDX_OUT),
        .dat      (VPS_DAT_OUT),
        .vld      (VPS_VLD_OUT),
        .done     (VPS_DONE_OUT)
    );

endmodule

// File: tb/tb_prt_vtb_ctl_mc.sv
// Directed self-checking bench for prt_vtb_ctl_mc (8 IG, 8 OG, 16x16 VPS).
module tb_prt_vtb_ctl_mc;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [255:0]   ig_in;
    logic [255:0]   og_out;
    logic           sof = 1'b0;
    logic [3:0]     vps_idx;
    logic [15:0]    vps_dat;
    logic           vps_vld;
    logic           vps_done;
    int             n_chk = 0;
    int             n_err = 0;

    prt_dp_lb_if lb();

    prt_vtb_ctl_mc #(
        .P_VENDOR    ("none"),
        .P_IG_PORTS  (8),
        .P_OG_PORTS  (8),
        .P_VPS_DEPTH (16),
        .P_VPS_WIDTH (16)
    ) dut (
        .SYS_CLK_IN   (clk),
        .SYS_RST_IN   (rst_n),
        .LB_IF        (lb),
        .IG_IN        (ig_in),
        .OG_OUT       (og_out),
        .SOF_IN       (sof),
        .VPS_IDX_OUT  (vps_idx),
        .VPS_DAT_OUT  (vps_dat),
        .VPS_VLD_OUT  (vps_vld),
        .VPS_DONE_OUT (vps_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Both bus tasks start and end on a falling edge.
    task automatic lb_write(input logic [7:0] a, input logic [31:0] d);
        lb.adr = a; lb.din = d; lb.wr = 1'b1;
        @(negedge clk);
        lb.wr = 1'b0;
    endtask

    task automatic lb_read(input logic [7:0] a, output logic [31:0] d);
        lb.adr = a; lb.rd = 1'b1;
        @(negedge clk);
        lb.rd = 1'b0;
        @(negedge clk);
        check("rd_vld", {31'b0, lb.vld}, 32'd1);
        d = lb.dout;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          hits;
        int          dones;

        lb.adr = '0; lb.din = '0; lb.wr = 1'b0; lb.rd = 1'b0;
        for (int i = 0; i < 8; i++) ig_in[i*32 +: 32] = 32'h100 + 32'(i);

        // Reset state
        #12;
        check("rst_og", og_out[31:0] | og_out[127:96] | og_out[255:224], 32'd0);
        check("rst_vld", {31'b0, vps_vld}, 32'd0);
        check("rst_lb_vld", {31'b0, lb.vld}, 32'd0);
        check("rst_dout", lb.dout, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // OG write and its one-clock output latency
        lb_write(8'd0, 32'h0000_0300);
        lb_write(8'd2, 32'hDEAD_BEEF);
        check("og_before", og_out[127:96], 32'd0);
        @(negedge clk);
        check("og_after", og_out[127:96], 32'hDEAD_BEEF);
        lb.adr = 8'd2; lb.rd = 1'b1;
        @(negedge clk);
        lb.rd = 1'b0;
        check("vld_1clk", {31'b0, lb.vld}, 32'd0);
        @(negedge clk);
        check("vld_2clk", {31'b0, lb.vld}, 32'd1);
        check("og_rd", lb.dout, 32'hDEAD_BEEF);
        @(negedge clk);
        check("vld_3clk", {31'b0, lb.vld}, 32'd0);
        lb_read(8'd0, d); check("ctl_rd", d, 32'h0000_0300);

        // IG readback with auto-increment and wrap
        lb_write(8'd0, 32'h0100_0006);
        lb_read(8'd1, d); check("ig_6", d, 32'h106);
        lb_read(8'd1, d); check("ig_7", d, 32'h107);
        lb_read(8'd1, d); check("ig_wrap0", d, 32'h100);
        lb_read(8'd1, d); check("ig_1", d, 32'h101);
        lb_read(8'd0, d); check("ctl_ig2", d, 32'h0100_0002);

        // Out-of-range indices
        lb_write(8'd0, 32'h0000_0909);
        lb_write(8'd2, 32'h1234_5678);
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            check($sformatf("oor_og_w%0d", i), og_out[i*32 +: 32],
                  (i == 3) ? 32'hDEAD_BEEF : 32'd0);
        lb_read(8'd2, d); check("oor_og_rd", d, 32'd0);
        lb_read(8'd1, d); check("oor_ig_rd", d, 32'd0);
        lb_read(8'd7, d); check("unmapped_rd", d, 32'd0);

        // Same-cycle write and read returns the pre-write value
        lb_write(8'd0, 32'h0000_0300);
        lb.adr = 8'd2; lb.din = 32'hCAFE_F00D; lb.wr = 1'b1; lb.rd = 1'b1;
        @(negedge clk);
        lb.wr = 1'b0; lb.rd = 1'b0;
        @(negedge clk);
        check("wrrd_vld", {31'b0, lb.vld}, 32'd1);
        check("wrrd_old", lb.dout, 32'hDEAD_BEEF);
        check("wrrd_og", og_out[127:96], 32'hCAFE_F00D);

        // SOF while idle does nothing
        sof = 1'b1; @(negedge clk); sof = 1'b0; @(negedge clk);
        check("sof_idle", {31'b0, vps_vld}, 32'd0);

        // Deferred commit
        lb_write(8'd0, 32'h0100_0000);
        for (int n = 0; n < 16; n++) lb_write(8'd3, 32'h10 + 32'(n));
        lb_read(8'd3, d); check("shadow0", d, 32'h10);
        lb_write(8'd0, 32'h0200_0000);
        hits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (vps_vld || vps_done) hits++;
        end
        check("pend_no_burst", hits, 0);
        lb_read(8'd4, d); check("sts_pend", d, 32'h0000_0001);
        sof = 1'b1; @(negedge clk); sof = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("burst_vld%0d", k), {31'b0, vps_vld}, 32'd1);
            check($sformatf("burst_idx%0d", k), {28'b0, vps_idx}, 32'(k));
            check($sformatf("burst_dat%0d", k), {16'b0, vps_dat}, 32'h10 + 32'(k));
            @(negedge clk);
        end
        check("burst_end_vld", {31'b0, vps_vld}, 32'd0);
        check("done_pulse", {31'b0, vps_done}, 32'd1);
        @(negedge clk);
        check("done_once", {31'b0, vps_done}, 32'd0);
        lb_read(8'd4, d); check("sts_cnt1", d, 32'h0000_0100);

        // Immediate commit with collisions
        lb_write(8'd0, 32'h0600_0000);
        check("imm_not_yet", {31'b0, vps_vld}, 32'd0);
        lb_write(8'd0, 32'h0200_0000);
        check("imm_start", {31'b0, vps_vld}, 32'd1);
        check("imm_idx0", {28'b0, vps_idx}, 32'd0);
        lb_write(8'd3, 32'h0000_00AA);
        hits = 1; dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (vps_vld) hits++;
            if (vps_done) begin dones++; break; end
            @(negedge clk);
        end
        check("imm_len", hits, 16);
        check("imm_done", dones, 1);
        repeat (3) @(negedge clk);
        check("no_rerun", {31'b0, vps_vld}, 32'd0);
        lb_read(8'd4, d); check("sts_ovr_werr", d, 32'h0000_020C);
        lb_read(8'd3, d); check("shadow_kept", d, 32'h10);
        lb_write(8'd4, 32'h0000_000C);
        lb_read(8'd4, d); check("sts_clr", d, 32'h0000_0200);

        // Reset in the middle of a burst
        lb_write(8'd0, 32'h0600_0000);
        repeat (6) @(negedge clk);
        check("mid_idx5", {28'b0, vps_idx}, 32'd5);
        rst_n = 1'b0;
        #1;
        check("rst_vld_now", {31'b0, vps_vld}, 32'd0);
        check("rst_idx_now", {28'b0, vps_idx}, 32'd0);
        check("rst_dat_now", {16'b0, vps_dat}, 32'd0);
        check("rst_og_now", og_out[127:96], 32'd0);
        dones = 0;
        repeat (3) begin @(negedge clk); if (vps_done) dones++; end
        rst_n = 1'b1;
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (vps_done) dones++;
            if (vps_vld) hits++;
        end
        check("rst_no_done", dones, 0);
        check("rst_idle", hits, 0);
        lb_read(8'd0, d); check("rst_ctl", d, 32'd0);
        lb_read(8'd4, d); check("rst_sts", d, 32'd0);
        lb_read(8'd3, d); check("rst_shadow", d, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
